mips_cpu_regfile_scoreboard: RTL
================================

Name: mips_cpu_regfile_scoreboard

Overview:
- Parametrised successor to mips_cpu_registers: a 2^ADDR_WIDTH x DATA_WIDTH general-purpose register file.
- Provides two combinational read ports and two write ports: port 0 for ALU writeback, port 1 for load/memory return.
- Adds three things the old file lacks: a pending-load scoreboard with per-read busy flags, optional write-through bypass, and HI/LO registers for mult/div.
- Sits between the decode stage (reads, busy) and the writeback stage (writes), inside mips_cpu.

Parameters:
DATA_WIDTH, 32, width of every register, HI and LO.
ADDR_WIDTH, 5, register index width; depth = 2^ADDR_WIDTH.
BYPASS, 1, 1 = same-cycle write data is forwarded to the read outputs; 0 = reads return stored contents only.

Ports:
clk  in  1  clock; all state changes on posedge.
reset_n  in  1  asynchronous, active-low reset.
rdAddrA  in  ADDR_WIDTH  read port A index.
rdDataA  out  DATA_WIDTH  read port A data.
rdBusyA  out  1  rdAddrA has an outstanding load.
rdAddrB  in  ADDR_WIDTH  read port B index.
rdDataB  out  DATA_WIDTH  read port B data.
rdBusyB  out  1  rdAddrB has an outstanding load.
write0  in  1  ALU write enable.
wrAddr0  in  ADDR_WIDTH  ALU write index.
wrData0  in  DATA_WIDTH  ALU write data.
write1  in  1  load-return write enable.
wrAddr1  in  ADDR_WIDTH  load-return index.
wrData1  in  DATA_WIDTH  load-return data.
pendSet  in  1  mark pendAddr as awaiting a load.
pendAddr  in  ADDR_WIDTH  index to mark.
hiWrite  in  1  HI write enable.
hiData  in  DATA_WIDTH  HI write data.
loWrite  in  1  LO write enable.
loData  in  DATA_WIDTH  LO write data.
hi  out  DATA_WIDTH  HI value.
lo  out  DATA_WIDTH  LO value.
err  out  1  sticky protocol-error flag.

Behaviour:
- Clock and reset are fixed: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Reset (reset_n=0, asynchronous, holds while low):
  - all registers, HI and LO are 0;
  - every pending bit is cleared;
  - err=0, rdBusyA=rdBusyB=0.
  - Writes and pendSet are ignored while reset is low; the first write is accepted at the first posedge after reset_n rises.
- Register 0:
  - always reads 0;
  - write0/write1 to index 0 are discarded;
  - pendSet to index 0 is discarded; its busy flag is always 0.
- Reads are combinational: zero-cycle latency from rdAddr to rdData/rdBusy.
- Writes commit at posedge and are visible on the read ports from then on.
- Dual write, same address, same cycle: port 0 wins (the ALU result is the younger instruction). err is unaffected.
- Bypass (BYPASS=1): if a write is enabled this cycle to a nonzero rdAddrX, rdDataX shows that write data before the edge; port 0 data takes priority.
- HI/LO follow the same bypass rule: with BYPASS=1, hi=hiData while hiWrite=1, and lo=loData while loWrite=1.
- With BYPASS=0, every read output shows only stored state.
- Scoreboard: one pending bit per register.
  - pendSet sets pending[pendAddr] at posedge.
  - A write1 to an address clears its pending bit at posedge.
  - pendSet and write1 to the same address in one cycle: the bit ends set (a new load has been issued).
  - Several loads may be pending at once, on distinct addresses.
- rdBusyX = pending[rdAddrX].
  - With BYPASS=1, rdBusyX is 0 in a cycle where write1 targets rdAddrX, since the data is forwarded.
- err: set at posedge, and held until reset, on any of:
  - write0 to a nonzero address whose pending bit is set and which is not being cleared by write1 in the same cycle;
  - pendSet to an address already pending;
  - write1 to an address that is not pending.
- Protocol-error writes are still performed with normal priority rules; err only flags them.
- A mid-operation reset drops all pending loads; a load return arriving afterwards sets err.

Test Plan:
- Reset, then read all 32 indices on A and B -> every rdData=0, busy=0, hi=lo=0, err=0. Assert reset_n=0 mid-clock after writes -> outputs 0 immediately, without waiting for an edge.
- write0 r5=0xDEADBEEF, then read A=5, B=0 -> rdDataA=0xDEADBEEF, rdDataB=0. write0 r0=0x1234 -> r0 still reads 0.
- Same cycle: write0 r7=0x11111111 and write1 r7=0x22222222, with r7 pending -> after the edge r7=0x11111111. With BYPASS=1, rdAddrA=7 shows 0x11111111 in that cycle.
- pendSet r9, next cycle rdAddrA=9 -> rdBusyA=1. write1 r9=0xCAFEF00D -> same cycle busy=0 and data forwarded (BYPASS=1); after the edge r9=0xCAFEF00D, pending clear, err=0.
- Protocol errors, each from a fresh reset: write1 r3 with nothing pending -> err=1 next edge and stays 1; pendSet r4 twice -> err=1; write0 r4 while r4 is pending -> err=1, r4 is still written.
- Random run, 1000 cycles, BYPASS=0 and BYPASS=1 builds, against a shadow model covering regs, pending, HI/LO and err, with a 1% random reset_n pulse -> zero mismatches.

Source files
------------

// File: rtl/mips_cpu_regfile_scoreboard.sv
// Register file with a pending-load scoreboard, HI/LO and optional same-cycle write bypass.
// Reads are combinational; registers, pending bits, HI/LO and the sticky err flag update on posedge clk.
module mips_cpu_regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] rdAddrA,
  output logic [DATA_WIDTH-1:0] rdDataA,
  output logic                  rdBusyA,
  input  logic [ADDR_WIDTH-1:0] rdAddrB,
  output logic [DATA_WIDTH-1:0] rdDataB,
  output logic                  rdBusyB,
  input  logic                  write0,
  input  logic [ADDR_WIDTH-1:0] wrAddr0,
  input  logic [DATA_WIDTH-1:0] wrData0,
  input  logic                  write1,
  input  logic [ADDR_WIDTH-1:0] wrAddr1,
  input  logic [DATA_WIDTH-1:0] wrData1,
  input  logic                  pendSet,
  input  logic [ADDR_WIDTH-1:0] pendAddr,
  input  logic                  hiWrite,
  input  logic [DATA_WIDTH-1:0] hiData,
  input  logic                  loWrite,
  input  logic [DATA_WIDTH-1:0] loData,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      pending;
  logic [DEPTH-1:0]      pending_next;
  logic [DATA_WIDTH-1:0] hi_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic                  err_q;
  logic                  err_next;
  logic                  wr0_ok;
  logic                  wr1_ok;
  logic                  pset_ok;
  logic                  byp_en;

  assign wr0_ok  = write0 && (wrAddr0 != '0);
  assign wr1_ok  = write1 && (wrAddr1 != '0);
  assign pset_ok = pendSet && (pendAddr != '0);
  // Forwarding is suppressed while in reset so the outputs read as zero immediately.
  assign byp_en  = BYPASS && reset_n;

  // A load issued in the same cycle as a return to that register leaves it pending.
  always_comb begin
    pending_next = pending;
    if (write1)  pending_next[wrAddr1]  = 1'b0;
    if (pset_ok) pending_next[pendAddr] = 1'b1;
  end

  always_comb begin
    err_next = err_q;
    if (wr0_ok && pending[wrAddr0] && !(write1 && (wrAddr1 == wrAddr0))) err_next = 1'b1;
    if (pset_ok && pending[pendAddr]) err_next = 1'b1;
    if (write1 && !pending[wrAddr1]) err_next = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pending <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      // Port 0 is assigned last so it wins a same-address collision.
      if (wr1_ok) regs[wrAddr1] <= wrData1;
      if (wr0_ok) regs[wrAddr0] <= wrData0;
      if (hiWrite) hi_q <= hiData;
      if (loWrite) lo_q <= loData;
      pending <= pending_next;
      err_q   <= err_next;
    end
  end

  always_comb begin
    rdDataA = regs[rdAddrA];
    if (byp_en && wr1_ok && (wrAddr1 == rdAddrA)) rdDataA = wrData1;
    if (byp_en && wr0_ok && (wrAddr0 == rdAddrA)) rdDataA = wrData0;
    if (rdAddrA == '0) rdDataA = '0;
    rdBusyA = pending[rdAddrA] && !(byp_en && write1 && (wrAddr1 == rdAddrA));
  end

  always_comb begin
    rdDataB = regs[rdAddrB];
    if (byp_en && wr1_ok && (wrAddr1 == rdAddrB)) rdDataB = wrData1;
    if (byp_en && wr0_ok && (wrAddr0 == rdAddrB)) rdDataB = wrData0;
    if (rdAddrB == '0) rdDataB = '0;
    rdBusyB = pending[rdAddrB] && !(byp_en && write1 && (wrAddr1 == rdAddrB));
  end

  assign hi  = (byp_en && hiWrite) ? hiData : hi_q;
  assign lo  = (byp_en && loWrite) ? loData : lo_q;
  assign err = err_q;

endmodule
